// File: rtl/ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage_pkg
// Purpose  : Shared definitions for the execute stage. Holds the aluop codes,
//            the alusel result classes, the zero word and the divider state
//            encoding.
// Revision : 1.0 - initial release
// ============================================================================
package ex_stage_pkg;

  // ALU operation codes
  localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  // Result class selects
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // Divider FSM states
  typedef enum logic [1:0] {
    DIV_IDLE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  function automatic logic is_div_op(input logic [7:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_stage_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Purpose  : Iterative radix-2 restoring divider, one quotient bit per clock.
//            Signed operands are divided as magnitudes and sign-corrected on
//            the way out.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            start_i           - a divide is being requested this cycle
//            signed_i          - treat operands as two's complement
//            opdata1_i/2_i     - dividend / divisor
//            annul_i           - abort any in-flight divide
//            result_o[63:0]    - {remainder, quotient}, valid while ready_o
//            ready_o           - divider sits in END with a finished result
// Revision : 1.0 - initial release
// ============================================================================
module div_unit
  import ex_stage_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      dvd_q, dvd_d;   // dividend, shifted out as quotient shifts in
  logic [31:0]      dvs_q, dvs_d;
  logic [31:0]      rem_q, rem_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;

  logic [31:0] w_abs1, w_abs2;
  logic [32:0] w_trial, w_diff;

  assign w_abs1  = (signed_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign w_abs2  = (signed_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
  // Partial remainder is always below the divisor, so the trial fits in 33 bits.
  assign w_trial = {rem_q, dvd_q[31]};
  assign w_diff  = w_trial - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    case (state_q)
      DIV_IDLE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == ZERO_WORD) begin
            state_d = DIV_BY_ZERO;
            dvd_d   = ZERO_WORD;
            rem_d   = ZERO_WORD;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
          end else begin
            state_d = DIV_ON;
            dvd_d   = w_abs1;
            dvs_d   = w_abs2;
            rem_d   = ZERO_WORD;
            cnt_d   = '0;
            qneg_d  = signed_i && (opdata1_i[31] ^ opdata2_i[31]);
            rneg_d  = signed_i && opdata1_i[31];
          end
        end
      end
      DIV_BY_ZERO: begin
        state_d = annul_i ? DIV_IDLE : DIV_END;
      end
      DIV_ON: begin
        if (annul_i) begin
          state_d = DIV_IDLE;
        end else begin
          if (!w_diff[32]) begin
            rem_d = w_diff[31:0];
            dvd_d = {dvd_q[30:0], 1'b1};
          end else begin
            rem_d = w_trial[31:0];
            dvd_d = {dvd_q[30:0], 1'b0};
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
            state_d = DIV_END;
          end
        end
      end
      DIV_END: begin
        if (!start_i || annul_i) begin
          state_d = DIV_IDLE;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      dvd_q   <= ZERO_WORD;
      dvs_q   <= ZERO_WORD;
      rem_q   <= ZERO_WORD;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  // Quotient negated when operand signs differ; remainder follows the dividend.
  assign result_o = {(rneg_q ? (~rem_q + 32'd1) : rem_q),
                     (qneg_q ? (~dvd_q + 32'd1) : dvd_q)};
  assign ready_o  = (state_q == DIV_END);

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage
// Purpose  : Execute stage. Computes logic/shift results combinationally and
//            runs DIV/DIVU through an iterative divider, stalling the pipe
//            until the quotient/remainder are ready.
// Ports    : clk, rst                  - clock, synchronous active-high reset
//            annul_i                   - flush, aborts an in-flight divide
//            aluop_i, alusel_i         - operation and result class
//            reg1_i, reg2_i            - operands
//            wd_i, wreg_i / wd_o, wreg_o - destination pass-through
//            wdata_o                   - GPR write data
//            whilo_o, hi_o, lo_o       - HI/LO write (remainder/quotient)
//            stallreq_o                - stall request to pipeline control
// Revision : 1.0 - initial release
// ============================================================================
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        annul_i,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o
);

  logic        w_is_div;
  logic [63:0] w_div_result;
  logic        w_div_ready;
  logic [31:0] w_logic, w_shift, w_wdata;

  assign w_is_div = is_div_op(aluop_i);

  div_unit #(
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div_unit (
    .clk       (clk),
    .rst       (rst),
    .start_i   (w_is_div),
    .signed_i  (aluop_i == EXE_DIV_OP),
    .opdata1_i (reg1_i),
    .opdata2_i (reg2_i),
    .annul_i   (annul_i),
    .result_o  (w_div_result),
    .ready_o   (w_div_ready)
  );

  always_comb begin
    w_logic = ZERO_WORD;
    case (aluop_i)
      EXE_OR_OP:  w_logic = reg1_i | reg2_i;
      EXE_AND_OP: w_logic = reg1_i & reg2_i;
      EXE_XOR_OP: w_logic = reg1_i ^ reg2_i;
      EXE_NOR_OP: w_logic = ~(reg1_i | reg2_i);
      default:    w_logic = ZERO_WORD;
    endcase
  end

  always_comb begin
    w_shift = ZERO_WORD;
    case (aluop_i)
      EXE_SLL_OP: w_shift = reg2_i << reg1_i[4:0];
      EXE_SRL_OP: w_shift = reg2_i >> reg1_i[4:0];
      EXE_SRA_OP: w_shift = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
      default:    w_shift = ZERO_WORD;
    endcase
  end

  always_comb begin
    w_wdata = ZERO_WORD;
    case (alusel_i)
      EXE_RES_LOGIC: w_wdata = w_logic;
      EXE_RES_SHIFT: w_wdata = w_shift;
      default:       w_wdata = ZERO_WORD;
    endcase
  end

  // Outputs are forced to zero while reset is held so the forwarding path
  // never presents stale data.
  assign wd_o       = rst ? 5'd0 : wd_i;
  assign wreg_o     = !rst && wreg_i;
  assign wdata_o    = rst ? ZERO_WORD : w_wdata;
  assign stallreq_o = !rst && w_is_div && !w_div_ready;
  assign whilo_o    = !rst && w_is_div && w_div_ready;
  assign hi_o       = whilo_o ? w_div_result[63:32] : ZERO_WORD;
  assign lo_o       = whilo_o ? w_div_result[31:0]  : ZERO_WORD;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_stage
// Purpose  : Directed self-checking bench for ex_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        annul_i;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i, reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o, lo_o;
  logic        stallreq_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_stage #(.DIV_CYCLES(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .annul_i    (annul_i),
    .aluop_i    (aluop_i),
    .alusel_i   (alusel_i),
    .reg1_i     (reg1_i),
    .reg2_i     (reg2_i),
    .wd_i       (wd_i),
    .wreg_i     (wreg_i),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o),
    .wdata_o    (wdata_o),
    .whilo_o    (whilo_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .stallreq_o (stallreq_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [7:0] op, input logic [2:0] sel,
                        input logic [31:0] a, input logic [31:0] b);
    aluop_i  = op;
    alusel_i = sel;
    reg1_i   = a;
    reg2_i   = b;
  endtask

  // Combinational op: apply, settle, compare.
  task automatic comb_vec(input string tag, input logic [7:0] op, input logic [2:0] sel,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    set_op(op, sel, a, b);
    #1;
    check_eq(tag, {32'd0, wdata_o}, {32'd0, exp});
  endtask

  // Divide already applied at posedge+1; counts stall cycles, then checks the
  // completion cycle and that the op retires cleanly. Ends at posedge+1.
  task automatic wait_div(input string tag, input int exp_stall,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int stalls = 0;
    int early  = 0;
    bit done   = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (stallreq_o) begin
        stalls++;
        if (whilo_o) early++;
        tick();
      end else begin
        done = 1;
      end
    end
    check_eq({tag, "_stalls"}, stalls, exp_stall);
    check_eq({tag, "_early_whilo"}, early, 0);
    check_eq({tag, "_whilo"}, {63'd0, whilo_o}, 64'd1);
    check_eq({tag, "_lo"}, {32'd0, lo_o}, {32'd0, exp_lo});
    check_eq({tag, "_hi"}, {32'd0, hi_o}, {32'd0, exp_hi});
    tick();
    aluop_i = 8'h00;
    @(negedge clk);
    check_eq({tag, "_retire"}, {62'd0, whilo_o, stallreq_o}, 64'd0);
    tick();
  endtask

  task automatic do_div(input string tag, input logic [7:0] op,
                        input logic [31:0] a, input logic [31:0] b, input int exp_stall,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    set_op(op, 3'b000, a, b);
    wait_div(tag, exp_stall, exp_lo, exp_hi);
  endtask

  initial begin
    rst = 1'b1; annul_i = 1'b0; wd_i = 5'd5; wreg_i = 1'b1;
    set_op(EXE_DIVU_OP, 3'b000, 32'd100, 32'd7);
    tick(); tick(); tick();
    @(negedge clk);
    check_eq("rst_stall", {63'd0, stallreq_o}, 64'd0);
    check_eq("rst_whilo", {63'd0, whilo_o}, 64'd0);
    check_eq("rst_hilo", {hi_o, lo_o}, 64'd0);
    check_eq("rst_wd_wreg", {58'd0, wd_o, wreg_o}, 64'd0);
    set_op(EXE_OR_OP, EXE_RES_LOGIC, 32'h0000_FF00, 32'h00F0_F0F0);
    #1;
    check_eq("rst_wdata", {32'd0, wdata_o}, 64'd0);
    tick();
    rst = 1'b0;

    // Logic and shift, zero latency
    comb_vec("or", EXE_OR_OP, EXE_RES_LOGIC, 32'h0000_FF00, 32'h00F0_F0F0, 32'h00F0_FFF0);
    check_eq("or_wd_wreg", {58'd0, wd_o, wreg_o}, {58'd0, 5'd5, 1'b1});
    check_eq("or_stall", {63'd0, stallreq_o}, 64'd0);
    comb_vec("nor", EXE_NOR_OP, EXE_RES_LOGIC, 32'h0000_FF00, 32'h00F0_F0F0, 32'hFF0F_000F);
    comb_vec("and", EXE_AND_OP, EXE_RES_LOGIC, 32'h0000_FF00, 32'h00F0_F0F0, 32'h0000_F000);
    comb_vec("xor", EXE_XOR_OP, EXE_RES_LOGIC, 32'h0000_FF00, 32'h00F0_F0F0, 32'h00F0_0FF0);
    comb_vec("sra", EXE_SRA_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0010, 32'hF800_0001);
    comb_vec("srl", EXE_SRL_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0010, 32'h0800_0001);
    comb_vec("sll_hi_ignored", EXE_SLL_OP, EXE_RES_SHIFT, 32'h0000_0021, 32'h1234_5678, 32'h2468_ACF0);
    comb_vec("bad_sel", EXE_OR_OP, 3'b111, 32'hFFFF_FFFF, 32'h1, 32'h0);
    wd_i = 5'd17; wreg_i = 1'b0;
    #1;
    check_eq("pass_wd_wreg", {58'd0, wd_o, wreg_o}, {58'd0, 5'd17, 1'b0});
    set_op(8'h00, 3'b000, 32'd0, 32'd0);
    tick();

    // Divides
    do_div("divu_100_7", EXE_DIVU_OP, 32'd100, 32'd7, 33, 32'd14, 32'd2);
    do_div("div_m7_2", EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    do_div("div_min_m1", EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0);
    do_div("divu_max_16", EXE_DIVU_OP, 32'hFFFF_FFFF, 32'd16, 33, 32'h0FFF_FFFF, 32'd15);
    do_div("divu_by0", EXE_DIVU_OP, 32'd5, 32'd0, 2, 32'd0, 32'd0);

    // Annul at cycle 10, then an immediate fresh divide must run full length
    set_op(EXE_DIV_OP, 3'b000, 32'd1000, 32'd3);
    for (int i = 0; i < 10; i++) tick();
    annul_i = 1'b1;
    tick();
    annul_i = 1'b0;
    aluop_i = 8'h00;
    @(negedge clk);
    check_eq("annul_idle", {62'd0, whilo_o, stallreq_o}, 64'd0);
    tick();
    do_div("after_annul", EXE_DIVU_OP, 32'd100, 32'd7, 33, 32'd14, 32'd2);

    // Reset mid-divide, then the held divide restarts from scratch
    set_op(EXE_DIV_OP, 3'b000, 32'hFFFF_FFF9, 32'd2);
    wd_i = 5'd9; wreg_i = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check_eq("midrst_outs", {56'd0, wd_o, wreg_o, whilo_o, stallreq_o}, 64'd0);
    check_eq("midrst_hilo", {hi_o, lo_o}, 64'd0);
    tick();
    rst = 1'b0;
    wait_div("rst_restart", 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
